div8by4_seq: RTL and testbench

//  Sequential restoring divider; inverse of the 4x4 array multiplier.

---
 rtl/div8by4_seq_if.sv | 25 ++
 rtl/div8by4_seq.sv | 106 ++++++++++
 tb/tb_div8by4_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/div8by4_seq_if.sv
// rtl/div8by4_seq_if.sv - operand/result handshake bundle for the sequential divider
interface div8by4_seq_if #(
  parameter int N = 8,
  parameter int D = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [D-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [D-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div8by4_seq.sv
// rtl/div8by4_seq.sv - restoring divider, one quotient bit per clock, MSB first
module div8by4_seq #(
  parameter int N = 8,
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           rst,
  div8by4_seq_if.slave   bus
);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [N-1:0]     dvd_q,   dvd_d;
  logic [D-1:0]     dvs_q,   dvs_d;
  logic [D:0]       pr_q,    pr_d;
  logic [N-1:0]     quo_q,   quo_d;
  logic             dbz_q,   dbz_d;

  logic             accept;
  logic [D:0]       pr_shift;
  logic [D:0]       pr_diff;
  logic             q_bit;

  assign accept   = bus.in_valid && (state_q == S_IDLE);
  // The extra partial-remainder bit keeps the shifted value comparable without overflow.
  assign pr_shift = {pr_q[D-1:0], dvd_q[N-1]};
  assign q_bit    = (pr_shift >= {1'b0, dvs_q});
  assign pr_diff  = pr_shift - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    quo_d   = quo_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.divisor == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            pr_d    = {1'b0, bus.dividend[D-1:0]};
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            dvd_d   = bus.dividend;
            dvs_d   = bus.divisor;
            pr_d    = '0;
            quo_d   = '0;
            dbz_d   = 1'b0;
            cnt_d   = CNT_W'(N - 1);
          end
        end
      end
      S_CALC: begin
        dvd_d = dvd_q << 1;
        pr_d  = q_bit ? pr_diff : pr_shift;
        quo_d = {quo_q[N-2:0], q_bit};
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      quo_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = pr_q[D-1:0];
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div8by4_seq.sv
// tb/tb_div8by4_seq.sv - randomized and directed bench against an arithmetic reference model
module tb_div8by4_seq;
  localparam int N = 8;
  localparam int D = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  div8by4_seq_if #(.N(N), .D(D)) bus ();

  div8by4_seq #(.N(N), .D(D)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int a, input int b,
                                output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << N) - 1;
      r = a % (1 << D);
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  function automatic int mult4b(input int a, input int b);
    return a * b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) check({tag, "_idle_timeout"}, 0, 1);
  endtask

  // One full transaction: accept, optional busy-input noise, optional backpressure, handshake.
  task automatic run_op(input int a, input int b, input int hold, input bit noise,
                        input bit quick, input string tag);
    int eq, er, ez, lat;
    model(a, b, eq, er, ez);
    wait_idle(tag);
    bus.in_valid = 1'b1;
    bus.dividend = N'(a);
    bus.divisor  = D'(b);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (noise) begin
        bus.in_valid = 1'b1;
        bus.dividend = N'($urandom);
        bus.divisor  = D'($urandom);
      end
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    if (!quick) check({tag, "_latency"}, lat, (b == 0) ? 0 : N);
    else if (lat >= 40) check({tag, "_timeout"}, lat, N);
    check({tag, "_quotient"}, bus.quotient, eq);
    check({tag, "_remainder"}, bus.remainder, er);
    check({tag, "_dbz"}, bus.div_by_zero, ez);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = noise;
      bus.dividend = N'($urandom);
      bus.divisor  = D'($urandom);
      tick();
      check({tag, "_hold_quotient"}, bus.quotient, eq);
      check({tag, "_hold_remainder"}, bus.remainder, er);
      check({tag, "_hold_dbz"}, bus.div_by_zero, ez);
      check({tag, "_hold_in_ready"}, bus.in_ready, 0);
      check({tag, "_hold_out_valid"}, bus.out_valid, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    if (!quick) begin
      check({tag, "_post_in_ready"}, bus.in_ready, 1);
      check({tag, "_post_out_valid"}, bus.out_valid, 0);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_dbz", bus.div_by_zero, 0);
    rst = 1'b0;
    tick();

    run_op(200, 7, 0, 1'b0, 1'b0, "d200_7");
    run_op(255, 1, 0, 1'b0, 1'b0, "d255_1");
    run_op(3, 15, 0, 1'b0, 1'b0, "d3_15");
    run_op(9, 0, 0, 1'b0, 1'b0, "d9_0");
    run_op(200, 7, 5, 1'b0, 1'b0, "bp200_7");
    run_op(200, 7, 0, 1'b1, 1'b0, "busy200_7");
    run_op(9, 0, 5, 1'b1, 1'b0, "bp9_0");

    // Reset lands on the third CALC posedge after the accept.
    wait_idle("rst_mid");
    bus.in_valid = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_in_ready", bus.in_ready, 1);
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_quotient", bus.quotient, 0);
    check("rst_mid_remainder", bus.remainder, 0);
    check("rst_mid_dbz", bus.div_by_zero, 0);
    run_op(100, 10, 0, 1'b0, 1'b0, "after_rst_100_10");

    for (int i = 0; i < 300; i++) begin
      run_op($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b0, "rand");
    end

    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 256; a++) begin
        run_op(a, b, 0, 1'b0, 1'b1, "exh");
      end
    end

    for (int a = 1; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        wait_idle("rt");
        bus.in_valid = 1'b1;
        bus.dividend = N'(mult4b(a, b));
        bus.divisor  = D'(a);
        tick();
        bus.in_valid = 1'b0;
        for (int w = 0; w < 40 && !bus.out_valid; w++) tick();
        check("rt_quotient", bus.quotient, b);
        check("rt_remainder", bus.remainder, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
